// File: rtl/dc_router_pkg.sv
// Shared definitions for the dc_router datapath: accelerator select codes,
// sequencer state encoding and the select-to-lane decoder.
package dc_router_pkg;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_FFT  = 2'b01;
  localparam logic [1:0] ACC_FIR  = 2'b10;
  localparam logic [1:0] ACC_IIR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lane order matches the FIFO buses: bit0 FFT, bit1 FIR, bit2 IIR.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    case (sel)
      ACC_FFT: return 3'b001;
      ACC_FIR: return 3'b010;
      ACC_IIR: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/dc_ram_sequencer.sv
// Streams one file from shared RAM into the selected accelerator and writes the
// accelerator's results back in place over the single RAM port.
module dc_ram_sequencer
  import dc_router_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          acc_sel,
  input  logic [ADDR_W-1:0]   offset,
  input  logic [CNT_W-1:0]    filesize,
  output logic                ram_read_enable,
  output logic                ram_write_enable,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  input  logic [2:0]          to_acc_full,
  output logic [2:0]          to_acc_put,
  output logic [DATA_W-1:0]   to_acc_data,
  input  logic [2:0]          from_acc_empty,
  output logic [2:0]          from_acc_get,
  input  logic [3*DATA_W-1:0] from_acc_data,
  output logic [2:0]          acc_enable,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t             state, state_nx;
  logic [1:0]         sel_q;
  logic [ADDR_W-1:0]  offset_q;
  logic [CNT_W-1:0]   size_q;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   wr_cnt;
  logic               rd_pending;
  logic               err_q;

  logic [2:0]         lane;
  logic [DATA_W-1:0]  head_data;
  logic               out_empty;
  logic               in_full;
  logic               in_run;
  logic               wr_go;
  logic               rd_go;
  logic               legal_start;
  logic               illegal_start;

  assign lane          = sel_onehot(sel_q);
  assign out_empty     = |(from_acc_empty & lane);
  assign in_full       = |(to_acc_full & lane);
  assign legal_start   = (state == IDLE) && start && (acc_sel != ACC_NONE);
  assign illegal_start = (state == IDLE) && start && (acc_sel == ACC_NONE);

  // Qualifying with reset makes an abort take effect in the reset cycle itself,
  // so no FIFO pop or RAM write slips through before the state register clears.
  assign in_run = reset && (state == RUN);

  // Draining the output FIFO always wins the RAM port; it is what keeps the
  // accelerator moving and so guarantees forward progress.
  assign wr_go = in_run && (wr_cnt < size_q) && !out_empty;
  assign rd_go = in_run && !wr_go && (rd_cnt < size_q) && !in_full && !rd_pending;

  always_comb begin
    head_data = '0;
    case (sel_q)
      ACC_FFT: head_data = from_acc_data[0        +: DATA_W];
      ACC_FIR: head_data = from_acc_data[DATA_W   +: DATA_W];
      ACC_IIR: head_data = from_acc_data[2*DATA_W +: DATA_W];
      default: head_data = '0;
    endcase
  end

  // NOTE: every output and the next state get a default before any branch so
  // that no path leaves them unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_nx         = state;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    ram_addr         = '0;
    ram_wdata        = '0;
    to_acc_put       = '0;
    to_acc_data      = '0;
    from_acc_get     = '0;
    acc_enable       = '0;
    busy             = in_run;
    done             = reset && (state == DONE);
    err              = reset && err_q;

    case (state)
      IDLE: if (legal_start) state_nx = (filesize == '0) ? DONE : RUN;
      RUN:  if ((wr_cnt == size_q) && !rd_pending) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (wr_go) begin
      ram_write_enable = 1'b1;
      ram_addr         = offset_q + ADDR_W'(wr_cnt);
      ram_wdata        = head_data;
      from_acc_get     = lane;
    end else if (rd_go) begin
      ram_read_enable  = 1'b1;
      ram_addr         = offset_q + ADDR_W'(rd_cnt);
    end

    // Read data returns one cycle after the strobe; pushing it here leaves the
    // RAM port free for a write in the same cycle.
    if (in_run && rd_pending) begin
      to_acc_put  = lane;
      to_acc_data = ram_rdata;
    end

    if (in_run) acc_enable = lane;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      sel_q      <= ACC_NONE;
      offset_q   <= '0;
      size_q     <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      rd_pending <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      err_q      <= illegal_start;
      rd_pending <= rd_go;
      if (legal_start) begin
        sel_q    <= acc_sel;
        offset_q <= offset;
        size_q   <= filesize;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
      end
      if (wr_go) wr_cnt <= wr_cnt + CNT_W'(1);
      if (rd_go) rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/dc_ram_sequencer.md
Name: dc_ram_sequencer

Overview:
- Moves one data file between shared RAM and the selected accelerator (FFT, FIR or IIR).
- On a start pulse it reads filesize words beginning at offset and pushes them into the selected accelerator's input FIFO.
- In parallel it drains that accelerator's output FIFO and writes the results back in place, starting at offset.
- Sits between the instruction decode / acc_done logic and the RAM port of dc_router; drives the per-accelerator enables.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 32, data word width
CNT_W, 16, file size / counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to begin a transfer
acc_sel  in  2  01 = FFT, 10 = FIR, 11 = IIR, 00 = illegal
offset  in  ADDR_W  base RAM address; sampled at start
filesize  in  CNT_W  number of words; sampled at start
ram_read_enable  out  1  RAM read strobe
ram_write_enable  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_read_enable
to_acc_full  in  3  input-FIFO full flags, bit0 FFT, bit1 FIR, bit2 IIR
to_acc_put  out  3  input-FIFO push, one-hot
to_acc_data  out  DATA_W  input-FIFO push data
from_acc_empty  in  3  output-FIFO empty flags
from_acc_get  out  3  output-FIFO pop, one-hot; data is first-word-fall-through
from_acc_data  in  3*DATA_W  output-FIFO head words, FFT in [DATA_W-1:0]
acc_enable  out  3  fft/fir/iir enable, one-hot
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer completion
err  out  1  one-cycle pulse on illegal start

Behaviour:
- Reset (reset == 0 at posedge clk): all outputs 0, both counters 0, state IDLE. Reset mid-transfer aborts immediately; no further RAM or FIFO strobes are issued.
- State IDLE:
  - start with acc_sel != 00: latch acc_sel, offset and filesize; clear rd_cnt and wr_cnt; go to RUN. acc_enable goes high the next cycle.
  - start with acc_sel == 00: err = 1 for one cycle; stay in IDLE.
  - filesize == 0 with a legal start: go directly to DONE. No RAM access occurs.
- State RUN: busy = 1, and acc_enable[sel] = 1. The RAM has a single port, so at most one strobe is issued per cycle.
  - Write eligible: wr_cnt < filesize and from_acc_empty[sel] == 0.
    - Asserts from_acc_get[sel], ram_write_enable, ram_addr = offset + wr_cnt, and ram_wdata = from_acc_data[sel].
    - Increments wr_cnt.
  - Read eligible: no write issued this cycle, rd_cnt < filesize, to_acc_full[sel] == 0, and no read in flight.
    - Asserts ram_read_enable and ram_addr = offset + rd_cnt.
    - Increments rd_cnt and sets rd_pending.
  - Writes take priority over reads, so the output FIFO always drains and the path cannot deadlock.
  - rd_pending cycle: to_acc_put[sel] = 1 and to_acc_data = ram_rdata; rd_pending then clears. The RAM port is free that cycle for a write.
  - Read throughput is at most one word per 2 cycles. This is the chosen policy: it guarantees the push never lands on a full FIFO.
  - In-place safety: the accelerator emits no more words than it has consumed, so wr_cnt < rd_cnt always holds whenever a write issues.
  - Exit: when wr_cnt == filesize and rd_pending == 0, go to DONE.
- State DONE: lasts one cycle. done = 1, busy = 0, acc_enable = 0; then return to IDLE.
- start while in RUN or DONE is ignored. No err is raised.
- Address arithmetic: offset + count is truncated to ADDR_W, so addresses wrap modulo 2^ADDR_W. Counters are CNT_W wide; filesize up to 2^CNT_W - 1 is legal.
- Strobes for non-selected accelerators stay 0 at all times.

Decomposition:
- Package dc_router_pkg holds:
  - ACC_FFT = 2'b01, ACC_FIR = 2'b10, ACC_IIR = 2'b11;
  - state encoding IDLE/RUN/DONE;
  - a sel-to-one-hot function.
- No sub-module. The 3-way FIFO mux and demux stays inline.

Test Plan:
- FFT, offset 0x0100, filesize 4, FIFOs never full, output FIFO fills only after 4 pushes:
  - 4 reads at 0x0100..0x0103 on alternate cycles, then 4 writes at 0x0100..0x0103 with popped data;
  - done pulses once; acc_enable = 001 throughout RUN.
- FIR streaming, filesize 8, output word appears 2 cycles after each push:
  - reads and writes interleave, never in the same cycle;
  - write address is always below the last read address;
  - exactly 8 of each, then done.
- IIR, to_acc_full[2] held high for 10 cycles mid-file: no ram_read_enable while full; transfer resumes and completes with correct counts.
- Illegal and zero-length starts:
  - acc_sel = 00 with start gives err = 1 for one cycle, busy stays 0;
  - filesize = 0 gives done one cycle later with no RAM strobes.
- Wrap and reset cases:
  - offset 0xFFFE, filesize 4: read addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - reset low after the 2nd read: next cycle all outputs are 0 and state is IDLE.
  - A new start afterwards completes normally.
